// File: rtl/matrix_frame_scheduler.sv
// rtl/matrix_frame_scheduler.sv - double-buffered LED matrix frame store and scan sequencer
// Scan side reads the front buffer one pixel per cycle; swaps only land on the last fetch of a frame.
module matrix_frame_scheduler #(
   parameter int COLS      = 32,
   parameter int HALF_ROWS = 16,
   parameter int RGB_W     = 3,
   localparam int COL_W    = $clog2(COLS),
   localparam int ROW_W    = $clog2(HALF_ROWS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [COL_W-1:0] wr_x,
   input  logic [ROW_W:0]   wr_y,
   input  logic [RGB_W-1:0] wr_rgb,
   input  logic             swap_req,
   input  logic             blank,
   output logic             swap_ack,
   output logic             front_sel,
   output logic [RGB_W-1:0] rgb1_bus,
   output logic [RGB_W-1:0] rgb2_bus,
   output logic [COL_W-1:0] scan_col,
   output logic [ROW_W-1:0] scan_row,
   output logic             frame_start
);
   localparam int AW    = 1 + ROW_W + COL_W;
   localparam int DEPTH = 2 * HALF_ROWS * COLS;

   typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

   state_t           r_state;
   logic [RGB_W-1:0] r_mem_up [DEPTH];
   logic [RGB_W-1:0] r_mem_lo [DEPTH];
   logic [COL_W-1:0] r_fcol;
   logic [ROW_W-1:0] r_frow;
   logic [COL_W-1:0] r_scan_col;
   logic [ROW_W-1:0] r_scan_row;
   logic [RGB_W-1:0] r_rgb1;
   logic [RGB_W-1:0] r_rgb2;
   logic             r_front;
   logic             r_ack;
   logic             r_fs;

   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_rd_addr;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_boundary;

   // Writes always target the buffer not on display, so no read/write collision exists.
   assign w_wr_addr  = {~r_front, wr_y[ROW_W-1:0], wr_x};
   assign w_rd_addr  = {r_front, r_frow, r_fcol};
   assign w_col_last = (r_fcol == COL_W'(COLS - 1));
   assign w_row_last = (r_frow == ROW_W'(HALF_ROWS - 1));
   assign w_boundary = w_col_last && w_row_last;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_y[ROW_W]) r_mem_lo[w_wr_addr] <= wr_rgb;
         else             r_mem_up[w_wr_addr] <= wr_rgb;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_fcol     <= '0;
         r_frow     <= '0;
         r_scan_col <= '0;
         r_scan_row <= '0;
         r_rgb1     <= '0;
         r_rgb2     <= '0;
         r_front    <= 1'b0;
         r_ack      <= 1'b0;
         r_fs       <= 1'b0;
      end else begin
         r_rgb1     <= r_mem_up[w_rd_addr];
         r_rgb2     <= r_mem_lo[w_rd_addr];
         r_scan_col <= r_fcol;
         r_scan_row <= r_frow;
         r_fs       <= (r_fcol == '0) && (r_frow == '0);

         if (w_col_last) begin
            r_fcol <= '0;
            r_frow <= w_row_last ? '0 : r_frow + 1'b1;
         end else begin
            r_fcol <= r_fcol + 1'b1;
         end

         // The toggle at the last fetch makes the very next fetch (0,0) come from the new front.
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (swap_req) begin
                  if (w_boundary) begin
                     r_front <= ~r_front;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state <= S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (!swap_req) begin
                  r_state <= S_IDLE;
               end else if (w_boundary) begin
                  r_front <= ~r_front;
                  r_ack   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign swap_ack    = r_ack;
   assign front_sel   = r_front;
   assign rgb1_bus    = blank ? '0 : r_rgb1;
   assign rgb2_bus    = blank ? '0 : r_rgb2;
   assign scan_col    = r_scan_col;
   assign scan_row    = r_scan_row;
   assign frame_start = r_fs;
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb/tb_matrix_frame_scheduler.sv - scoreboard bench for matrix_frame_scheduler
// Pixel-index reference model pushes one expectation per clock; a negedge monitor pops and compares.
module tb_matrix_frame_scheduler;
   localparam int COLS  = 32;
   localparam int HR    = 16;
   localparam int FRAME = COLS * HR;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_x = '0;
   logic [4:0] wr_y = '0;
   logic [2:0] wr_rgb = '0;
   logic       swap_req = 1'b0;
   logic       blank = 1'b0;
   logic       swap_ack, front_sel, frame_start;
   logic [2:0] rgb1_bus, rgb2_bus;
   logic [4:0] scan_col;
   logic [3:0] scan_row;

   matrix_frame_scheduler #(.COLS(COLS), .HALF_ROWS(HR), .RGB_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_rgb(wr_rgb), .swap_req(swap_req), .blank(blank), .swap_ack(swap_ack),
      .front_sel(front_sel), .rgb1_bus(rgb1_bus), .rgb2_bus(rgb2_bus),
      .scan_col(scan_col), .scan_row(scan_row), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ack; int fs; int front; int col; int row;
      int r1; int r2; bit c1; bit c2;
   } exp_t;

   exp_t     q[$];
   int       fb[2][32][32];
   bit       known[2][32][32];
   int       m_k = 0;
   int       m_front = 0;
   int       passed = 0;
   int       total = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: the n-th edge after release fetches linear pixel n-1 of the frame.
   always @(posedge clk) begin
      exp_t e;
      int   p;
      if (!reset_n) begin
         m_k = 0; m_front = 0;
         e.ack = 0; e.fs = 0; e.front = 0; e.col = 0; e.row = 0;
         e.r1 = 0; e.r2 = 0; e.c1 = 1; e.c2 = 1;
      end else begin
         p = m_k;
         m_k++;
         e.col = p % COLS;
         e.row = (p / COLS) % HR;
         e.r1  = fb[m_front][e.row][e.col];
         e.c1  = known[m_front][e.row][e.col];
         e.r2  = fb[m_front][e.row + HR][e.col];
         e.c2  = known[m_front][e.row + HR][e.col];
         e.fs  = (p % FRAME == 0) ? 1 : 0;
         e.ack = (swap_req && (p % FRAME == FRAME - 1)) ? 1 : 0;
         if (wr_en) begin
            fb[1 - m_front][wr_y][wr_x]    = int'(wr_rgb);
            known[1 - m_front][wr_y][wr_x] = 1'b1;
         end
         if (e.ack == 1) m_front = 1 - m_front;
         e.front = m_front;
      end
      q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (q.size() == 0) begin
         check("queue_underflow", 0, 1);
      end else begin
         e = q.pop_front();
         check("swap_ack", int'(swap_ack), e.ack);
         check("front_sel", int'(front_sel), e.front);
         check("frame_start", int'(frame_start), e.fs);
         check("scan_col", int'(scan_col), e.col);
         check("scan_row", int'(scan_row), e.row);
         if (blank || e.c1) check("rgb1_bus", int'(rgb1_bus), blank ? 0 : e.r1);
         if (blank || e.c2) check("rgb2_bus", int'(rgb2_bus), blank ? 0 : e.r2);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic fill(input bit pattern);
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 32; x++) begin
            wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y);
            wr_rgb = pattern ? 3'(x) : 3'($urandom_range(0, 7));
            cyc();
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic wait_ack(input int lim, input string name, output int lat);
      lat = -1;
      for (int i = 0; i < lim; i++) begin
         cyc();
         if (swap_ack) begin lat = i + 1; break; end
      end
      check(name, (lat > 0) ? 1 : 0, 1);
   endtask

   task automatic wait_fetch(input int p);
      bit hit = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (m_k % FRAME == p) begin hit = 1; break; end
         cyc();
      end
      check("wait_fetch_reached", int'(hit), 1);
   endtask

   task automatic check_reset_zero(input string name);
      check(name, int'({rgb1_bus, rgb2_bus, scan_col, scan_row, frame_start, swap_ack, front_sel}), 0);
   endtask

   initial begin
      int lat, acks, old_front;
      bit hit;
      repeat (3) cyc();
      reset_n = 1'b1;

      fill(1'b0);
      swap_req = 1'b1; wait_ack(FRAME + 100, "preload_swap_ack", lat); swap_req = 1'b0;
      fill(1'b1);

      reset_n = 1'b0; #1;
      check_reset_zero("reset_async_outputs");
      cyc(); cyc();
      reset_n = 1'b1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("c1_frame_start", int'(frame_start), 1);
            check("c1_rgb1", int'(rgb1_bus), 0);
         end
         if (n == 6) begin
            check("c6_scan_col", int'(scan_col), 5);
            check("c6_rgb1", int'(rgb1_bus), 5);
         end
         if (n == 46) check("c46_scan_col", int'(scan_col), 13);
         #1;
         blank = (n + 1 >= 40 && n + 1 <= 45);
      end
      blank = 1'b0;

      wr_en = 1'b1; wr_x = 5'd3; wr_y = 5'd20; wr_rgb = 3'b101;
      cyc();
      wr_en = 1'b0;
      swap_req = 1'b1; wait_ack(FRAME + 100, "write_swap_ack", lat); swap_req = 1'b0;
      hit = 0;
      for (int i = 0; i < FRAME + 10; i++) begin
         cyc();
         if (scan_col == 5'd3 && scan_row == 4'd4) begin hit = 1; break; end
      end
      check("new_frame_pixel_3_20", hit ? int'(rgb2_bus) : -1, 5);

      wait_fetch(7 * COLS + 10);
      old_front = int'(front_sel);
      swap_req = 1'b1; wait_ack(FRAME + 10, "midframe_ack", lat); swap_req = 1'b0;
      check("midframe_ack_latency", lat, FRAME - (7 * COLS + 10));
      cyc();
      check("ack_one_cycle", int'(swap_ack), 0);
      repeat (20) cyc();
      check("front_toggled_once", int'(front_sel), old_front ^ 1);

      swap_req = 1'b1; acks = 0;
      for (int i = 0; i < 3 * FRAME + 100; i++) begin
         wr_en = 1'($urandom_range(0, 1));
         wr_x = 5'($urandom); wr_y = 5'($urandom); wr_rgb = 3'($urandom);
         cyc();
         if (swap_ack) acks++;
         if (acks == 3) break;
      end
      swap_req = 1'b0; wr_en = 1'b0;
      check("held_req_three_acks", acks, 3);

      wait_fetch(100);
      swap_req = 1'b1; repeat (50) cyc(); swap_req = 1'b0;
      acks = 0;
      for (int i = 0; i < FRAME + 50; i++) begin cyc(); if (swap_ack) acks++; end
      check("withdrawn_no_ack", acks, 0);

      wait_fetch(FRAME - 1);
      swap_req = 1'b1; cyc();
      check("boundary_req_ack", int'(swap_ack), 1);
      swap_req = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         wr_en = 1'($urandom_range(0, 1));
         wr_x = 5'($urandom); wr_y = 5'($urandom); wr_rgb = 3'($urandom);
         blank = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 63) == 0) swap_req = ~swap_req;
         cyc();
      end
      wr_en = 1'b0; blank = 1'b0; swap_req = 1'b0;
      cyc();

      swap_req = 1'b1;
      cyc();
      wait_fetch(9 * COLS + 17);
      reset_n = 1'b0; #1;
      check_reset_zero("midframe_reset_outputs");
      swap_req = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      acks = 0;
      for (int i = 0; i < FRAME + 50; i++) begin cyc(); if (swap_ack) acks++; end
      check("no_ack_after_reset", acks, 0);
      check("front_after_reset", int'(front_sel), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
